mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Sits between the load/store buffer and the fetch unit on one side, and the byte-wide unified RAM/IO port on the other.
- Serialises one word/half/byte access at a time into single-byte RAM cycles.
- Reassembles and sign/zero-extends load data, broadcasts load results on the CDB, and returns fetched instructions.
- Arbitration: LSB requests have priority over instruction fetch.

Parameters:
- IO_SEL, 2'b11: value of addr[17:16] that marks the memory-mapped IO region.
- INST_BYTES, 4: bytes per instruction fetch.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- rdy  in  1  global enable; when low, all state holds
- clear  in  1  branch-mispredict flush
- mem_din  in  8  RAM read byte; valid one cycle after mem_a
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  UART FIFO full
- lsb_ok  in  1  LSB request valid; held until done
- lsb_addr  in  32  base address
- lsb_imm  in  32  load offset (0 for stores)
- lsb_val  in  32  store data; for loads, [3:0] is the ROB tag
- lsb_opt  in  6  [5:3]: 101 = load, 111 = store; [2:0]: funct3
- to_lsb_ok  out  1  one-cycle done pulse
- if_ok  in  1  fetch request valid
- if_pc  in  32  fetch address
- to_if_ok  out  1  one-cycle fetch-done pulse
- to_if_inst  out  32  fetched instruction
- cdb_ok  out  1  load result valid (one cycle)
- cdb_en  out  4  load ROB tag
- cdb_val  out  32  extended load value

Behaviour:
- Reset (rst = 0, async): state = IDLE, cnt = 0. All outputs are 0: to_lsb_ok, to_if_ok, cdb_ok, mem_wr, mem_a, mem_dout, to_if_inst, cdb_val, cdb_en.
- rdy low: all registers hold; mem_wr is forced 0.
- States: IDLE, LOAD, STORE, FETCH, COOL.
- IDLE:
  - If lsb_ok and lsb_opt[5:3] = 101: latch ea = lsb_addr + lsb_imm (32-bit wrap), tag, and funct3. Set mem_a = ea, mem_wr = 0, go to LOAD.
  - Else if lsb_ok and lsb_opt[5:3] = 111: latch ea = lsb_addr and data. Go to STORE.
  - Else if if_ok and not clear: mem_a = if_pc, go to FETCH.
- Access size: N = 1/2/4 for funct3[1:0] = 00/01/10.
- LOAD / FETCH:
  - Each cycle, present the next address and capture mem_din into byte[cnt-1], little-endian.
  - Done after N+1 cycles from the IDLE decision (FETCH: INST_BYTES+1).
- STORE:
  - One byte per cycle: mem_wr = 1, mem_a = ea + cnt, mem_dout = data byte cnt.
  - N cycles total.
- Completion:
  - Load: to_lsb_ok = 1, cdb_ok = 1, cdb_en = tag, cdb_val extended. Sign-extend for funct3 000/001; zero-extend for 100/101; funct3 010 passes the word through.
  - Store: to_lsb_ok = 1 only.
  - Fetch: to_if_ok = 1, to_if_inst = word.
  - Pulses last exactly one cycle, then go to COOL.
- COOL: one idle cycle, mem_wr = 0. Absorbs the LSB's one-cycle-late drop of lsb_ok. Then go to IDLE.
- clear:
  - Aborts FETCH and LOAD: return to IDLE with no done pulse.
  - A STORE in progress always completes and pulses to_lsb_ok.
  - clear during COOL has no effect.
- Simultaneous lsb_ok and if_ok in IDLE: LSB wins; fetch waits.
- Address wrap: ea + cnt wraps modulo 2^32.
- Unaligned accesses are serviced byte-wise without fault.

Optional Feature:
- Macro MC_IO_STALL_EN.
- Defined: a STORE byte whose address has [17:16] == IO_SEL and arrives while io_buffer_full = 1 is held. mem_wr = 0, cnt is not advanced, and the state is retried each cycle until the buffer frees.
- Undefined: io_buffer_full is ignored; stores never stall.

Decomposition:
- Package mem_pkg: state encoding; opcode class constants LOAD = 3'b101 and STORE = 3'b111; funct3 constants; IO_SEL.
- Sub-module mem_extend: combinational sign/zero extension from (word, funct3). Instantiated once.

Test Plan:
- LW at lsb_addr = 0x100, lsb_imm = 4, RAM[0x104..0x107] = 78 56 34 12, tag = 5 → after 5 cycles: cdb_ok, cdb_en = 5, cdb_val = 0x12345678, to_lsb_ok for one cycle; no second accept during COOL.
- LB at an address holding 0x80 → cdb_val = 0xFFFFFF80. LBU at the same address → 0x00000080. LH of 0x8001 → 0xFFFF8001.
- SW 0xDEADBEEF to 0x200 → 4 write cycles on 0x200..0x203 with bytes EF BE AD DE. to_lsb_ok on the fifth cycle.
- if_ok (pc = 0x0) and lsb_ok (SB) asserted together → SB serviced first. Fetch completes afterwards with to_if_inst = RAM word at 0.
- FETCH in progress, clear at its 2nd cycle → no to_if_ok, back in IDLE next cycle. STORE in progress with clear → still completes.
- With MC_IO_STALL_EN: SB to 0x30000 with io_buffer_full = 1 for 3 cycles → mem_wr stays 0 for 3 cycles, then one write, then done. Without the macro → write happens immediately.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared state encoding, opcode classes, funct3 codes and sizing helper
// for the byte-serial memory controller.
package mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_FETCH,
    S_COOL
  } state_t;

  localparam logic [2:0] OPC_LOAD  = 3'b101;
  localparam logic [2:0] OPC_STORE = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] IO_SEL     = 2'b11;
  localparam int         INST_BYTES = 4;

  // Bytes moved for a given funct3; the unused size code falls back to a word.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_extend.sv
// Sign/zero extension of an assembled load word according to its funct3.
module mem_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = word_i;
    case (funct3_i)
      F3_B:    ext_o = {{24{word_i[7]}}, word_i[7:0]};
      F3_H:    ext_o = {{16{word_i[15]}}, word_i[15:0]};
      F3_W:    ext_o = word_i;
      F3_BU:   ext_o = {24'h000000, word_i[7:0]};
      F3_HU:   ext_o = {16'h0000, word_i[15:0]};
      default: ext_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: LSB loads/stores and instruction fetch over a
// byte-wide RAM/IO port. Define MC_IO_STALL_EN to hold IO stores while the UART buffer is full.
module mem_ctrl
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        lsb_ok,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_imm,
  input  logic [31:0] lsb_val,
  input  logic [5:0]  lsb_opt,
  output logic        to_lsb_ok,
  input  logic        if_ok,
  input  logic [31:0] if_pc,
  output logic        to_if_ok,
  output logic [31:0] to_if_inst,
  output logic        cdb_ok,
  output logic [3:0]  cdb_en,
  output logic [31:0] cdb_val
);

  localparam logic [2:0] FETCH_N = 3'(INST_BYTES);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  tag_q, tag_d;
  logic [2:0]  f3_q, f3_d;
  logic [23:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        to_lsb_ok_q, to_lsb_ok_d;
  logic        to_if_ok_q, to_if_ok_d;
  logic        cdb_ok_q, cdb_ok_d;
  logic [3:0]  cdb_en_q, cdb_en_d;
  logic [31:0] cdb_val_q, cdb_val_d;
  logic [31:0] to_if_inst_q, to_if_inst_d;

  logic        is_load, is_store;
  logic [31:0] ld_ea;
  logic [2:0]  ld_n;
  logic [31:0] ld_word, ld_ext;
  logic [31:0] st_addr, st_word;
  logic [2:0]  st_cnt;
  logic [7:0]  st_byte;
  logic        st_hold, st_issue;

  assign is_load  = lsb_ok && (lsb_opt[5:3] == OPC_LOAD);
  assign is_store = lsb_ok && (lsb_opt[5:3] == OPC_STORE);
  assign ld_ea    = lsb_addr + lsb_imm;
  assign ld_n     = access_bytes(f3_q);

  // The first store byte is issued straight from the request in IDLE.
  assign st_addr = (state_q == S_IDLE) ? lsb_addr : ea_q + {29'd0, cnt_q};
  assign st_word = (state_q == S_IDLE) ? lsb_val : data_q;
  assign st_cnt  = (state_q == S_IDLE) ? 3'd0 : cnt_q;
  assign st_byte = st_word[{st_cnt[1:0], 3'b000} +: 8];

`ifdef MC_IO_STALL_EN
  assign st_hold = io_buffer_full && (st_addr[17:16] == IO_SEL);
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign st_hold   = 1'b0;
`endif

  // The final byte is taken straight off mem_din in the completing cycle.
  always_comb begin
    case (ld_n)
      3'd1:    ld_word = {24'h000000, mem_din};
      3'd2:    ld_word = {16'h0000, mem_din, buf_q[7:0]};
      default: ld_word = {mem_din, buf_q[23:0]};
    endcase
  end

  mem_extend u_extend (
    .word_i   (ld_word),
    .funct3_i (f3_q),
    .ext_o    (ld_ext)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ea_d         = ea_q;
    data_d       = data_q;
    tag_d        = tag_q;
    f3_d         = f3_q;
    buf_d        = buf_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = 1'b0;
    to_lsb_ok_d  = 1'b0;
    to_if_ok_d   = 1'b0;
    cdb_ok_d     = 1'b0;
    cdb_en_d     = cdb_en_q;
    cdb_val_d    = cdb_val_q;
    to_if_inst_d = to_if_inst_q;
    st_issue     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_load) begin
          ea_d    = ld_ea;
          tag_d   = lsb_val[3:0];
          f3_d    = lsb_opt[2:0];
          mem_a_d = ld_ea;
          cnt_d   = 3'd0;
          state_d = S_LOAD;
        end else if (is_store) begin
          ea_d     = lsb_addr;
          data_d   = lsb_val;
          f3_d     = lsb_opt[2:0];
          cnt_d    = 3'd0;
          st_issue = !st_hold;
          state_d  = S_STORE;
        end else if (if_ok && !clear) begin
          mem_a_d = if_pc;
          cnt_d   = 3'd0;
          state_d = S_FETCH;
        end
      end
      S_LOAD: begin
        if (clear) begin
          state_d = S_IDLE;
        end else if (cnt_q == ld_n) begin
          to_lsb_ok_d = 1'b1;
          cdb_ok_d    = 1'b1;
          cdb_en_d    = tag_q;
          cdb_val_d   = ld_ext;
          state_d     = S_COOL;
        end else begin
          mem_a_d = mem_a_q + 32'd1;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_FETCH: begin
        if (clear) begin
          state_d = S_IDLE;
        end else if (cnt_q == FETCH_N) begin
          to_if_ok_d   = 1'b1;
          to_if_inst_d = {mem_din, buf_q[23:0]};
          state_d      = S_COOL;
        end else begin
          mem_a_d = mem_a_q + 32'd1;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_STORE: begin
        if (cnt_q == access_bytes(f3_q)) begin
          to_lsb_ok_d = 1'b1;
          state_d     = S_COOL;
        end else begin
          st_issue = !st_hold;
        end
      end
      S_COOL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Byte capture for multi-cycle reads; byte[cnt-1] arrives while cnt is current.
    if ((state_q == S_LOAD || state_q == S_FETCH) && !clear) begin
      case (cnt_q)
        3'd1:    buf_d[7:0]   = mem_din;
        3'd2:    buf_d[15:8]  = mem_din;
        3'd3:    buf_d[23:16] = mem_din;
        default: buf_d = buf_q;
      endcase
    end

    if (st_issue) begin
      mem_a_d    = st_addr;
      mem_dout_d = st_byte;
      mem_wr_d   = 1'b1;
      cnt_d      = st_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      ea_q         <= '0;
      data_q       <= '0;
      tag_q        <= '0;
      f3_q         <= '0;
      buf_q        <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      to_lsb_ok_q  <= 1'b0;
      to_if_ok_q   <= 1'b0;
      cdb_ok_q     <= 1'b0;
      cdb_en_q     <= '0;
      cdb_val_q    <= '0;
      to_if_inst_q <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ea_q         <= ea_d;
      data_q       <= data_d;
      tag_q        <= tag_d;
      f3_q         <= f3_d;
      buf_q        <= buf_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      to_lsb_ok_q  <= to_lsb_ok_d;
      to_if_ok_q   <= to_if_ok_d;
      cdb_ok_q     <= cdb_ok_d;
      cdb_en_q     <= cdb_en_d;
      cdb_val_q    <= cdb_val_d;
      to_if_inst_q <= to_if_inst_d;
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q && rdy;
  assign to_lsb_ok  = to_lsb_ok_q;
  assign to_if_ok   = to_if_ok_q;
  assign to_if_inst = to_if_inst_q;
  assign cdb_ok     = cdb_ok_q;
  assign cdb_en     = cdb_en_q;
  assign cdb_val    = cdb_val_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed loads, stores and fetches against a byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        lsb_ok, if_ok;
  logic [31:0] lsb_addr, lsb_imm, lsb_val, if_pc;
  logic [5:0]  lsb_opt;
  logic        to_lsb_ok, to_if_ok, cdb_ok;
  logic [31:0] to_if_inst, cdb_val;
  logic [3:0]  cdb_en;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .lsb_ok(lsb_ok), .lsb_addr(lsb_addr), .lsb_imm(lsb_imm), .lsb_val(lsb_val),
    .lsb_opt(lsb_opt), .to_lsb_ok(to_lsb_ok),
    .if_ok(if_ok), .if_pc(if_pc), .to_if_ok(to_if_ok), .to_if_inst(to_if_inst),
    .cdb_ok(cdb_ok), .cdb_en(cdb_en), .cdb_val(cdb_val)
  );

  localparam logic [2:0] K_LD = 3'b110;  // {to_lsb_ok, cdb_ok, to_if_ok}
  localparam logic [2:0] K_ST = 3'b100;
  localparam logic [2:0] K_IF = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] val;
    logic [3:0]  tag;
    int          lat;
    int          iss;
  } ev_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  ev_t exp_q[$];
  wr_t wr_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  tmo_cnt = 0;
  bit  fin_req = 1'b0;
  bit  fin_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM: registered read, preloaded while reset is held.
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      ram[12'h000] <= 8'h13;
      ram[12'h104] <= 8'h78; ram[12'h105] <= 8'h56;
      ram[12'h106] <= 8'h34; ram[12'h107] <= 8'h12;
      ram[12'h108] <= 8'h9A;
      ram[12'h110] <= 8'h80;
      ram[12'h120] <= 8'h01; ram[12'h121] <= 8'h80;
      ram[12'hFFF] <= 8'hAB;
      mem_din      <= 8'h00;
    end else begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT write and completion pulse is matched against the queues.
  initial begin
    ev_t e;
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_flags", {27'd0, to_lsb_ok, to_if_ok, cdb_ok, mem_wr, 1'b0}, 32'h0);
        chk("rst_dout_en", {20'd0, mem_dout, cdb_en}, 32'h0);
        chk("rst_cdb_val", cdb_val, 32'h0);
        chk("rst_inst", to_if_inst, 32'h0);
      end else begin
        if (mem_wr) begin
          chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
          if (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            chk("wr_addr", mem_a, w.addr);
            chk("wr_data", {24'd0, mem_dout}, {24'd0, w.data});
          end
        end
        if (to_lsb_ok || cdb_ok || to_if_ok) begin
          chk("ev_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ev_kind", {29'd0, to_lsb_ok, cdb_ok, to_if_ok}, {29'd0, e.kind});
            if (e.kind == K_LD) begin
              chk("cdb_val", cdb_val, e.val);
              chk("cdb_en", {28'd0, cdb_en}, {28'd0, e.tag});
            end
            if (e.kind == K_IF) chk("if_inst", to_if_inst, e.val);
            if (e.lat >= 0) chk("latency", 32'(cyc - e.iss), 32'(e.lat));
          end
        end
        if (fin_req && !fin_ack) begin
          chk("ev_left", 32'(exp_q.size()), 32'd0);
          chk("wr_left", 32'(wr_q.size()), 32'd0);
          chk("timeouts", 32'(tmo_cnt), 32'd0);
          fin_ack = 1'b1;
        end
      end
    end
  end

  function automatic void push_ev(logic [2:0] k, logic [31:0] v, logic [3:0] t, int lat);
    ev_t e;
    e.kind = k; e.val = v; e.tag = t; e.lat = lat; e.iss = cyc + 1;
    exp_q.push_back(e);
  endfunction

  function automatic void push_wr(logic [31:0] a, logic [7:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endfunction

  // Holds lsb_ok until the done pulse, then drops it one cycle late like the LSB.
  task automatic lsb_go(input logic [5:0] opt, input logic [31:0] a, input logic [31:0] imm,
                        input logic [31:0] v);
    int n;
    lsb_opt = opt; lsb_addr = a; lsb_imm = imm; lsb_val = v; lsb_ok = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!to_lsb_ok && n < 40);
    if (!to_lsb_ok) begin
      $display("timeout waiting for to_lsb_ok (addr %h)", a);
      tmo_cnt++;
    end
    @(posedge clk);
    #1 lsb_ok = 1'b0;
  endtask

  task automatic if_go(input logic [31:0] pc);
    int n;
    if_pc = pc; if_ok = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!to_if_ok && n < 40);
    if (!to_if_ok) begin
      $display("timeout waiting for to_if_ok (pc %h)", pc);
      tmo_cnt++;
    end
    if_ok = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] imm,
                         input logic [3:0] tag, input logic [31:0] expv, input int lat);
    @(negedge clk);
    push_ev(K_LD, expv, tag, lat);
    $display("load  f3=%b addr=%h imm=%h tag=%0d expect %h", f3, a, imm, tag, expv);
    lsb_go({3'b101, f3}, a, imm, {28'd0, tag});
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input int nb);
    @(negedge clk);
    for (int k = 0; k < nb; k++) push_wr(a + 32'(k), d[8*k +: 8]);
    push_ev(K_ST, 32'h0, 4'h0, nb);
    $display("store f3=%b addr=%h data=%h", f3, a, d);
    lsb_go({3'b111, f3}, a, 32'h0, d);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    lsb_ok = 1'b0; if_ok = 1'b0;
    lsb_addr = '0; lsb_imm = '0; lsb_val = '0; lsb_opt = '0; if_pc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    do_load(3'b010, 32'h100, 32'h4, 4'd5, 32'h12345678, 5);
    do_load(3'b000, 32'h110, 32'h0, 4'd1, 32'hFFFFFF80, 2);
    do_load(3'b100, 32'h110, 32'h0, 4'd2, 32'h00000080, 2);
    do_load(3'b001, 32'h120, 32'h0, 4'd3, 32'hFFFF8001, 3);
    do_load(3'b101, 32'hFFFFFFF0, 32'hF, 4'd4, 32'h000013AB, 3);
    do_load(3'b010, 32'h105, 32'h0, 4'd8, 32'h9A123456, 5);
    do_store(3'b010, 32'h200, 32'hDEADBEEF, 4);
    do_load(3'b010, 32'h200, 32'h0, 4'd6, 32'hDEADBEEF, 5);

    // SB and fetch requested together: the store goes first and is visible to the fetch.
    @(negedge clk);
    push_wr(32'h0, 8'h99);
    push_ev(K_ST, 32'h0, 4'h0, 1);
    push_ev(K_IF, 32'h00000099, 4'h0, -1);
    $display("sb addr=0 data=99 together with fetch pc=0");
    fork
      lsb_go({3'b111, 3'b000}, 32'h0, 32'h0, 32'h99);
      if_go(32'h0);
    join

    @(negedge clk);
    push_ev(K_IF, 32'h12345678, 4'h0, 5);
    $display("fetch pc=104");
    if_go(32'h104);

    // Fetch flushed in its second cycle; a load issued right after must see IDLE.
    @(negedge clk);
    if_pc = 32'h104; if_ok = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1; if_ok = 1'b0;
    $display("fetch pc=104 flushed by clear");
    @(negedge clk);
    clear = 1'b0;
    push_ev(K_LD, 32'hFFFFFF80, 4'd7, 2);
    $display("load  after flush addr=110 tag=7");
    lsb_go({3'b101, 3'b000}, 32'h110, 32'h0, 32'h7);

    // Store keeps going through a clear.
    @(negedge clk);
    push_wr(32'h300, 8'hEF);
    push_wr(32'h301, 8'hBE);
    push_ev(K_ST, 32'h0, 4'h0, 2);
    $display("sh addr=300 data=beef with clear mid-store");
    fork
      lsb_go({3'b111, 3'b001}, 32'h300, 32'h0, 32'h0000BEEF);
      begin
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
      end
    join

    // IO-region byte store while the UART buffer reports full for three edges.
    @(negedge clk);
    push_wr(32'h30000, 8'h41);
`ifdef MC_IO_STALL_EN
    push_ev(K_ST, 32'h0, 4'h0, 4);
`else
    push_ev(K_ST, 32'h0, 4'h0, 1);
`endif
    io_buffer_full = 1'b1;
    $display("sb addr=30000 data=41 with io_buffer_full for 3 cycles");
    fork
      lsb_go({3'b111, 3'b000}, 32'h30000, 32'h0, 32'h41);
      begin
        repeat (3) @(negedge clk);
        io_buffer_full = 1'b0;
      end
    join

    repeat (4) @(negedge clk);
    fin_req = 1'b1;
    for (int i = 0; i < 20 && !fin_ack; i++) @(posedge clk);
    if (!fin_ack) begin
      n_bad++;
      $display("FAIL monitor_final: got no final check, expected one");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
